uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/baud_controller.sv | 31 +++
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding, oversampling tick points and baud_select codes.
// Baud divisors assume a 14.7456 MHz clk with 16 sample ticks per bit.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned TICK_W     = 4;
   localparam int unsigned DIV_W      = 7;

   localparam logic [TICK_W-1:0] START_TICK = 4'd7;
   localparam logic [TICK_W-1:0] MID_TICK   = 4'd8;
   localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(OVERSAMPLE - 1);

   localparam logic [2:0] BAUD_9600   = 3'd0;
   localparam logic [2:0] BAUD_19200  = 3'd1;
   localparam logic [2:0] BAUD_38400  = 3'd2;
   localparam logic [2:0] BAUD_57600  = 3'd3;
   localparam logic [2:0] BAUD_115200 = 3'd4;
   localparam logic [2:0] BAUD_230400 = 3'd5;
   localparam logic [2:0] BAUD_460800 = 3'd6;
   localparam logic [2:0] BAUD_921600 = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Down-counter reload value (clocks per sample tick minus one).
   function automatic logic [DIV_W-1:0] tick_reload(input logic [2:0] code);
      logic [DIV_W-1:0] r;
      case (code)
         BAUD_9600:   r = 7'd95;
         BAUD_19200:  r = 7'd47;
         BAUD_38400:  r = 7'd23;
         BAUD_57600:  r = 7'd15;
         BAUD_115200: r = 7'd7;
         BAUD_230400: r = 7'd3;
         BAUD_460800: r = 7'd1;
         default:     r = 7'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/baud_controller.sv
// Sample-tick generator: one-cycle sample_enable pulse every (reload+1) clocks.
// A baud_select change is honoured at once by reloading whenever the count exceeds the new period.
module baud_controller
   import uart_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [2:0] baud_select_i,
   output logic       sample_enable_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d, reload;

   always_comb begin
      reload          = tick_reload(baud_select_i);
      sample_enable_o = (cnt_q == '0);
      cnt_d           = cnt_q - 1'b1;
      if ((cnt_q == '0) || (cnt_q > reload)) begin
         cnt_d = reload;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_BITS LSB-first, even parity, stop; 16x oversampled.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting over ticks 7/8/9 instead of a single tick-8 sample.
//
// state  | meaning
// IDLE   | waiting for synchronized 1->0 with Rx_EN high
// START  | validate start at tick 7, ride out the rest of the start bit
// DATA   | sample DATA_BITS payload bits, accumulate parity
// PARITY | sample parity bit, fold into running XOR (1 = error)
// STOP   | sample stop bit, publish result and pulse Rx_VALID
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DATA_BITS   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           baud_select,
   input  logic                 Rx_EN,
   input  logic                 RxD,
   output logic [DATA_BITS-1:0] Rx_DATA,
   output logic                 Rx_VALID,
   output logic                 Rx_PERROR,
   output logic                 Rx_FERROR
);

   localparam int unsigned BIT_W = $clog2(DATA_BITS);

   logic                   sample_enable;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_prev_q;
   logic                   rxd_s;
   logic                   bit_val;

   uart_state_t            state_q, state_d;
   logic [TICK_W-1:0]      tick_q, tick_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   valid_q, valid_d;

   baud_controller u_baud (
      .clk_i           (clk),
      .rst_i           (rst),
      .baud_select_i   (baud_select),
      .sample_enable_o (sample_enable)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '1;
         rxd_prev_q <= 1'b1;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], RxD};
         rxd_prev_q <= rxd_s;
      end
   end

   assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
   localparam logic [TICK_W-1:0] SAMPLE_TICK = MID_TICK + 4'd1;
   logic s7_q, s8_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s7_q <= 1'b1;
         s8_q <= 1'b1;
      end else if (sample_enable) begin
         if (tick_q == MID_TICK - 4'd1) s7_q <= rxd_s;
         if (tick_q == MID_TICK)        s8_q <= rxd_s;
      end
   end

   assign bit_val = (s7_q & s8_q) | (s7_q & rxd_s) | (s8_q & rxd_s);
`else
   localparam logic [TICK_W-1:0] SAMPLE_TICK = MID_TICK;
   assign bit_val = rxd_s;
`endif

   logic sample_pt, last_tick;
   assign sample_pt = sample_enable && (tick_q == SAMPLE_TICK);
   assign last_tick = sample_enable && (tick_q == LAST_TICK);

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      data_d  = data_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      valid_d = 1'b0;
      if (sample_enable) begin
         tick_d = tick_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            tick_d = '0;
            if (Rx_EN && rxd_prev_q && !rxd_s) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (sample_enable && (tick_q == START_TICK)) begin
               if (rxd_s) begin
                  state_d = ST_IDLE;
               end else begin
                  bit_d = '0;
                  par_d = 1'b0;
               end
            end else if (last_tick) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (sample_pt) begin
               shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
               par_d   = par_q ^ bit_val;
            end
            if (last_tick) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (sample_pt) begin
               par_d = par_q ^ bit_val;
            end
            if (last_tick) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (sample_pt) begin
               data_d  = shift_q;
               perr_d  = par_q;
               ferr_d  = ~bit_val;
               valid_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Disabling the receiver drops any frame in flight without publishing it.
      if (!Rx_EN && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         data_d  = data_q;
         perr_d  = perr_q;
         ferr_d  = ferr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         valid_q <= valid_d;
      end
   end

   assign Rx_DATA   = data_q;
   assign Rx_VALID  = valid_q;
   assign Rx_PERROR = perr_q;
   assign Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural transmitter drives RxD, a monitor pops expectations on Rx_VALID.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] baud_select;
   logic       Rx_EN;
   logic       RxD;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID;
   logic       Rx_PERROR;
   logic       Rx_FERROR;

   always #5 clk = ~clk;

   uart_rx dut (
      .clk         (clk),
      .rst         (rst),
      .baud_select (baud_select),
      .Rx_EN       (Rx_EN),
      .RxD         (RxD),
      .Rx_DATA     (Rx_DATA),
      .Rx_VALID    (Rx_VALID),
      .Rx_PERROR   (Rx_PERROR),
      .Rx_FERROR   (Rx_FERROR)
   );

   // expected {data, perror, ferror}
   logic [9:0]  sb[$];
   int          n_cmp  = 0;
   int          n_bad  = 0;
   int          vcount = 0;
   int unsigned div_tbl[8] = '{96, 48, 24, 16, 8, 4, 2, 1};
   int unsigned bit_clks = 16;

   always @(negedge clk) begin
      if (Rx_VALID === 1'b1) begin
         logic [9:0] exp;
         vcount++;
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_valid: got data=%h perr=%b ferr=%b, expected no pulse",
                     Rx_DATA, Rx_PERROR, Rx_FERROR);
         end else begin
            exp = sb.pop_front();
            if ({Rx_DATA, Rx_PERROR, Rx_FERROR} !== exp) begin
               n_bad++;
               $display("FAIL frame: got data=%h perr=%b ferr=%b, expected data=%h perr=%b ferr=%b",
                        Rx_DATA, Rx_PERROR, Rx_FERROR, exp[9:2], exp[1], exp[0]);
            end
         end
      end
   end

   task automatic set_baud(input int code);
      baud_select = 3'(code);
      bit_clks    = 16 * div_tbl[code];
   endtask

   task automatic idle_bits(input int n);
      RxD = 1'b1;
      repeat (n * bit_clks) @(negedge clk);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 4 * int'(bit_clks) + 64; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
   endtask

   // abort_bit >= 0: mid data bit abort_bit, pulse rst (use_rst) or drop Rx_EN for 2 clocks
   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                             input int abort_bit, input bit use_rst);
      logic [10:0] fr;
      logic        par_b, stop_b;
      par_b  = bad_par  ? 1'b0 : ^d;
      stop_b = bad_stop ? 1'b0 : 1'b1;
      fr     = {stop_b, par_b, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         RxD = fr[i];
         if (abort_bit >= 0 && i == abort_bit + 1) begin
            repeat (bit_clks / 2) @(negedge clk);
            if (use_rst) rst = 1'b1;
            else         Rx_EN = 1'b0;
            repeat (2) @(negedge clk);
            rst   = 1'b0;
            Rx_EN = 1'b1;
            repeat (bit_clks - bit_clks / 2 - 2) @(negedge clk);
         end else begin
            repeat (bit_clks) @(negedge clk);
         end
      end
      RxD = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; Rx_EN = 1'b1; RxD = 1'b1; set_baud(7);
      repeat (4) @(negedge clk);
      n_cmp++; if (Rx_DATA !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", Rx_DATA); end
      n_cmp++; if (Rx_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", Rx_VALID); end
      n_cmp++; if (Rx_PERROR !== 1'b0) begin n_bad++; $display("FAIL reset_perr: got %b expected 0", Rx_PERROR); end
      n_cmp++; if (Rx_FERROR !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b expected 0", Rx_FERROR); end
      rst = 1'b0;
      idle_bits(2);
   endtask

   task automatic test_basic();
      int v0 = vcount;
      sb.push_back({8'hA5, 1'b0, 1'b0});
      send_frame(8'hA5, 1'b0, 1'b0, -1, 1'b0);
      wait_drain();
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL basic_drain: got %0d pending expected 0", sb.size()); sb.delete(); end
      idle_bits(4);
      n_cmp++; if (vcount - v0 != 1) begin n_bad++; $display("FAIL basic_pulses: got %0d expected 1", vcount - v0); end
      n_cmp++; if (Rx_DATA !== 8'hA5) begin n_bad++; $display("FAIL basic_hold: got %h expected a5", Rx_DATA); end
   endtask

   task automatic test_parity();
      sb.push_back({8'h07, 1'b1, 1'b0});
      send_frame(8'h07, 1'b1, 1'b0, -1, 1'b0);
      wait_drain();
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL parity_drain: got %0d pending expected 0", sb.size()); sb.delete(); end
      idle_bits(2);
      n_cmp++; if (Rx_PERROR !== 1'b1) begin n_bad++; $display("FAIL parity_hold: got %b expected 1", Rx_PERROR); end
   endtask

   task automatic test_framing();
      int v0 = vcount;
      sb.push_back({8'h3C, 1'b0, 1'b1});
      send_frame(8'h3C, 1'b0, 1'b1, -1, 1'b0);
      RxD = 1'b0;
      repeat (3 * bit_clks) @(negedge clk);
      n_cmp++; if (vcount - v0 != 1) begin n_bad++; $display("FAIL framing_pulses: got %0d expected 1", vcount - v0); end
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL framing_drain: got %0d pending expected 0", sb.size()); sb.delete(); end
      idle_bits(2);
      sb.push_back({8'h81, 1'b0, 1'b0});
      send_frame(8'h81, 1'b0, 1'b0, -1, 1'b0);
      wait_drain();
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL framing_recover: got %0d pending expected 0", sb.size()); sb.delete(); end
      idle_bits(1);
   endtask

   task automatic test_glitch();
      int v0 = vcount;
      RxD = 1'b0;
      repeat (4 * div_tbl[baud_select]) @(negedge clk);
      idle_bits(3);
      n_cmp++; if (vcount != v0) begin n_bad++; $display("FAIL glitch_pulses: got %0d expected 0", vcount - v0); end
      sb.push_back({8'h55, 1'b0, 1'b0});
      send_frame(8'h55, 1'b0, 1'b0, -1, 1'b0);
      wait_drain();
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL glitch_recover: got %0d pending expected 0", sb.size()); sb.delete(); end
      idle_bits(1);
   endtask

   task automatic test_abort();
      int v0 = vcount;
      send_frame(8'hFE, 1'b0, 1'b0, 3, 1'b0);
      idle_bits(2);
      n_cmp++; if (vcount != v0) begin n_bad++; $display("FAIL en_abort_pulses: got %0d expected 0", vcount - v0); end
      sb.push_back({8'hFF, 1'b0, 1'b0});
      send_frame(8'hFF, 1'b0, 1'b0, -1, 1'b0);
      wait_drain();
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL en_abort_next: got %0d pending expected 0", sb.size()); sb.delete(); end
      idle_bits(1);
      v0 = vcount;
      send_frame(8'hFE, 1'b0, 1'b0, 3, 1'b1);
      idle_bits(2);
      n_cmp++; if (vcount != v0) begin n_bad++; $display("FAIL rst_abort_pulses: got %0d expected 0", vcount - v0); end
      n_cmp++; if (Rx_DATA !== 8'h00) begin n_bad++; $display("FAIL rst_abort_data: got %h expected 00", Rx_DATA); end
      sb.push_back({8'hFF, 1'b0, 1'b0});
      send_frame(8'hFF, 1'b0, 1'b0, -1, 1'b0);
      wait_drain();
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rst_abort_next: got %0d pending expected 0", sb.size()); sb.delete(); end
      idle_bits(1);
   endtask

   task automatic test_back_to_back();
      int v0 = vcount;
      sb.push_back({8'h00, 1'b0, 1'b0});
      sb.push_back({8'hFF, 1'b0, 1'b0});
      send_frame(8'h00, 1'b0, 1'b0, -1, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b0, -1, 1'b0);
      wait_drain();
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_drain: got %0d pending expected 0", sb.size()); sb.delete(); end
      idle_bits(1);
      n_cmp++; if (vcount - v0 != 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d expected 2", vcount - v0); end
   endtask

   task automatic test_loopback();
      for (int c = 0; c < 8; c++) begin
         logic [7:0] d;
         d = 8'($urandom_range(0, 255));
         set_baud(c);
         idle_bits(1);
         sb.push_back({d, 1'b0, 1'b0});
         send_frame(d, 1'b0, 1'b0, -1, 1'b0);
         wait_drain();
         n_cmp++;
         if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL loopback_baud%0d: got %0d pending expected 0 (data %h)", c, sb.size(), d);
            sb.delete();
         end
      end
   endtask

   initial begin
      baud_select = 3'd7;
      test_reset();
      test_basic();
      test_parity();
      test_framing();
      test_glitch();
      test_abort();
      test_back_to_back();
      test_loopback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
